// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch sequencing: per-register pending-write scoreboard, branch stall/resolve
// control with PC select and IF/ID flush, and saturating branch statistics.
module branch_hazard_ctrl #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [1:0]       BR_Type,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_wb_en,
  input  logic [4:0]       id_dest,
  input  logic             wb_en,
  input  logic [4:0]       wb_dest,
  input  logic             branch_taken,
  output logic             stall,
  output logic             pc_sel,
  output logic             flush_if,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned SB_W  = 2;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_BEZ  = 2'd1;
  localparam logic [1:0] BR_BNE  = 2'd2;

  localparam logic [SB_W-1:0]  SB_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [SB_W-1:0] cnt_q [NUM_REGS];
  logic [SB_W-1:0] cnt_d [NUM_REGS];

  logic [NUM_REGS-1:0] inc_c;
  logic [NUM_REGS-1:0] dec_c;

  logic [CNT_W-1:0] br_count_q,    br_count_d;
  logic [CNT_W-1:0] taken_count_q, taken_count_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic wb_hit_c;
  logic issue_c;
  logic need1_c, need2_c;
  logic src1_rdy_c, src2_rdy_c;
  logic br_act_c;
  logic hazard_c;
  logic resolve_c;

  // Operand need and readiness; a register retiring this cycle counts as ready (write-first RF)
  always_comb begin
    wb_hit_c = wb_en && (wb_dest != '0);
    br_act_c = id_valid && (BR_Type != BR_NONE);

    need1_c = 1'b0;
    need2_c = 1'b0;
    case (BR_Type)
      BR_BEZ: need1_c = 1'b1;
      BR_BNE: begin
        need1_c = 1'b1;
        need2_c = 1'b1;
      end
      default: begin
        need1_c = 1'b0;
        need2_c = 1'b0;
      end
    endcase

    src1_rdy_c = (id_src1 == '0) || (cnt_q[id_src1] == '0) ||
                 ((cnt_q[id_src1] == SB_W'(1)) && wb_hit_c && (wb_dest == id_src1));
    src2_rdy_c = (id_src2 == '0) || (cnt_q[id_src2] == '0) ||
                 ((cnt_q[id_src2] == SB_W'(1)) && wb_hit_c && (wb_dest == id_src2));

    hazard_c = br_act_c && ((need1_c && !src1_rdy_c) || (need2_c && !src2_rdy_c));
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a branch leaving ID while waiting (external flush) drops back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (hazard_c) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!br_act_c || !hazard_c) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: stall while operands are pending, otherwise resolve any branch in ID
  always_comb begin
    stall     = 1'b0;
    pc_sel    = 1'b0;
    flush_if  = 1'b0;
    resolve_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hazard_c) begin
          stall = 1'b1;
        end else if (br_act_c) begin
          resolve_c = 1'b1;
          pc_sel    = branch_taken;
          flush_if  = branch_taken;
        end
      end
      S_WAIT: begin
        if (hazard_c) begin
          stall = 1'b1;
        end else if (br_act_c) begin
          resolve_c = 1'b1;
          pc_sel    = branch_taken;
          flush_if  = branch_taken;
        end
      end
      default: begin
        stall     = 1'b0;
        resolve_c = 1'b0;
      end
    endcase
  end

  // Issue is suppressed while stalled, so the scoreboard only drains during a stall
  always_comb begin
    issue_c = id_valid && !stall && id_wb_en && (id_dest != '0);
    for (int i = 0; i < NUM_REGS; i++) begin
      inc_c[i] = issue_c  && (id_dest == REG_W'(i));
      dec_c[i] = wb_hit_c && (wb_dest == REG_W'(i));
    end
  end

  // Pending-write counters; simultaneous issue and writeback to one register cancel
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_c[i] && !dec_c[i] && (cnt_q[i] != SB_MAX)) begin
        cnt_d[i] = cnt_q[i] + SB_W'(1);
      end else if (dec_c[i] && !inc_c[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - SB_W'(1);
      end
    end
    cnt_d[0] = '0;
  end

  // Saturating statistics
  always_comb begin
    br_count_d    = br_count_q;
    taken_count_d = taken_count_q;
    stall_count_d = stall_count_q;
    if (resolve_c && (br_count_q != CNT_MAX)) begin
      br_count_d = br_count_q + CNT_W'(1);
    end
    if (resolve_c && branch_taken && (taken_count_q != CNT_MAX)) begin
      taken_count_d = taken_count_q + CNT_W'(1);
    end
    if (stall && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= '0;
      end
      br_count_q    <= '0;
      taken_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign br_count    = br_count_q;
  assign taken_count = taken_count_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Scoreboard bench for branch_hazard_ctrl: a full-width instance plus a 4-bit-counter
// instance sharing the same stimulus so counter saturation is reachable quickly.
module tb_branch_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [1:0]  br_type;
  logic [4:0]  id_src1, id_src2, id_dest, wb_dest;
  logic        id_wb_en, wb_en, branch_taken;

  logic        stall, pc_sel, flush_if;
  logic [15:0] br_count, taken_count, stall_count;
  logic        stall_s, pc_sel_s, flush_if_s;
  logic [3:0]  br_count_s, taken_count_s, stall_count_s;

  typedef struct packed {
    logic        st;
    logic        pc;
    logic [15:0] br;
    logic [15:0] tk;
    logic [15:0] sc;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  exp_t  e_cur;
  string nm_cur;
  int    n_cmp = 0;
  int    n_fail = 0;
  int    drain = 0;
  logic  done = 1'b0;

  always #5 clk = ~clk;

  branch_hazard_ctrl #(.NUM_REGS(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .BR_Type(br_type),
    .id_src1(id_src1), .id_src2(id_src2), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .wb_en(wb_en), .wb_dest(wb_dest), .branch_taken(branch_taken),
    .stall(stall), .pc_sel(pc_sel), .flush_if(flush_if),
    .br_count(br_count), .taken_count(taken_count), .stall_count(stall_count)
  );

  branch_hazard_ctrl #(.NUM_REGS(32), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .id_valid(id_valid), .BR_Type(br_type),
    .id_src1(id_src1), .id_src2(id_src2), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .wb_en(wb_en), .wb_dest(wb_dest), .branch_taken(branch_taken),
    .stall(stall_s), .pc_sel(pc_sel_s), .flush_if(flush_if_s),
    .br_count(br_count_s), .taken_count(taken_count_s), .stall_count(stall_count_s)
  );

  function automatic int sat4(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  function automatic void chk(input string nm, input string fld, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d expected %0d (t=%0t)", nm, fld, act, expv, $time);
    end
  endfunction

  // Drive one ID/WB cycle and queue the outputs expected during it
  task automatic step(input string nm, input logic v, input logic [1:0] bt,
                      input logic [4:0] s1, input logic [4:0] s2,
                      input logic iwe, input logic [4:0] idst,
                      input logic wbe, input logic [4:0] wbd, input logic tk,
                      input logic est, input logic epc,
                      input int ebr, input int etk, input int esc);
    exp_t e;
    id_valid = v; br_type = bt; id_src1 = s1; id_src2 = s2;
    id_wb_en = iwe; id_dest = idst; wb_en = wbe; wb_dest = wbd; branch_taken = tk;
    e.st = est; e.pc = epc; e.br = 16'(ebr); e.tk = 16'(etk); e.sc = 16'(esc);
    q.push_back(e);
    nq.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented cycle against the queued expectation
  always @(negedge clk) begin
    if (q.size() != 0) begin
      e_cur  = q.pop_front();
      nm_cur = nq.pop_front();
      chk(nm_cur, "stall",       int'(stall),       int'(e_cur.st));
      chk(nm_cur, "pc_sel",      int'(pc_sel),      int'(e_cur.pc));
      chk(nm_cur, "flush_if",    int'(flush_if),    int'(e_cur.pc));
      chk(nm_cur, "br_count",    int'(br_count),    int'(e_cur.br));
      chk(nm_cur, "taken_count", int'(taken_count), int'(e_cur.tk));
      chk(nm_cur, "stall_count", int'(stall_count), int'(e_cur.sc));
      chk(nm_cur, "stall_pc_excl", int'(stall & pc_sel), 0);
      chk(nm_cur, "stall_s",       int'(stall_s),       int'(e_cur.st));
      chk(nm_cur, "br_count_s",    int'(br_count_s),    sat4(int'(e_cur.br)));
      chk(nm_cur, "taken_count_s", int'(taken_count_s), sat4(int'(e_cur.tk)));
      chk(nm_cur, "stall_count_s", int'(stall_count_s), sat4(int'(e_cur.sc)));
    end
    if (!rst && id_valid && !stall && id_wb_en && id_dest != 5'd0 &&
        dut.cnt_q[id_dest] == 2'd3 && !(wb_en && wb_dest == id_dest)) begin
      n_fail++;
      $display("FAIL sb_overflow: reg %0d issued with 3 pending", id_dest);
    end
    if (!rst && wb_en && wb_dest != 5'd0 && dut.cnt_q[wb_dest] == 2'd0 &&
        !(id_valid && !stall && id_wb_en && id_dest == wb_dest)) begin
      n_fail++;
      $display("FAIL sb_underflow: reg %0d written back with none pending", wb_dest);
    end
    if (done) begin
      if (q.size() == 0) begin
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
      end else if (drain >= 8) begin
        n_fail++;
        $display("FAIL drain_timeout: %0d expectations left, required 0", q.size());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
      end else begin
        drain++;
      end
    end
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; br_type = 2'd0; id_src1 = '0; id_src2 = '0;
    id_wb_en = 1'b0; id_dest = '0; wb_en = 1'b0; wb_dest = '0; branch_taken = 1'b0;
    @(posedge clk);
    #1;
    step("reset",        0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    rst = 1'b0;
    // Hazard-free branch resolves in its ID cycle
    step("bez_nohaz",    1,1,5,0,0,0,0,0,1, 0,1,0,0,0);
    step("idle1",        0,0,0,0,0,0,0,0,0, 0,0,1,1,0);
    // Producer one ahead: two stalls, resolve at its WB
    step("add_r5",       1,0,1,2,1,5,0,0,0, 0,0,1,1,0);
    step("bne_stall1",   1,2,5,6,0,0,0,0,0, 1,0,1,1,0);
    step("bne_stall2",   1,2,5,6,0,0,0,0,0, 1,0,1,1,1);
    step("bne_resolve",  1,2,5,6,0,0,1,5,0, 0,0,1,1,2);
    step("idle2",        0,0,0,0,0,0,0,0,0, 0,0,2,1,2);
    // Producer two ahead: one stall
    step("add_r5b",      1,0,1,2,1,5,0,0,0, 0,0,2,1,2);
    step("nop",          1,0,0,0,0,0,0,0,0, 0,0,2,1,2);
    step("bez_stall",    1,1,5,0,0,0,0,0,1, 1,0,2,1,2);
    step("bez_resolve",  1,1,5,0,0,0,1,5,1, 0,1,2,1,3);
    // r0 is never tracked; JMP needs no operands
    step("add_r0",       1,0,1,2,1,0,0,0,0, 0,0,3,2,3);
    step("bez_r0",       1,1,0,0,0,0,0,0,1, 0,1,3,2,3);
    step("add_r5c",      1,0,1,2,1,5,0,0,0, 0,0,4,3,3);
    step("jmp",          1,3,5,5,0,0,0,0,1, 0,1,4,3,3);
    step("wb_r5",        0,0,0,0,0,0,1,5,0, 0,0,5,4,3);
    // Two writes in flight to r7: wait until the last one retires
    step("add_r7a",      1,0,1,2,1,7,0,0,0, 0,0,5,4,3);
    step("add_r7b",      1,0,1,2,1,7,0,0,0, 0,0,5,4,3);
    step("bne_r7_s1",    1,2,3,7,0,0,0,0,1, 1,0,5,4,3);
    step("bne_r7_wb1",   1,2,3,7,0,0,1,7,1, 1,0,5,4,4);
    step("bne_r7_s3",    1,2,3,7,0,0,0,0,1, 1,0,5,4,5);
    step("bne_r7_res",   1,2,3,7,0,0,1,7,1, 0,1,5,4,6);
    step("idle3",        0,0,0,0,0,0,0,0,0, 0,0,6,5,6);
    // External flush while waiting
    step("add_r9",       1,0,1,2,1,9,0,0,0, 0,0,6,5,6);
    step("bez_r9_st",    1,1,9,0,0,0,0,0,1, 1,0,6,5,6);
    step("drop_valid",   0,1,9,0,0,0,0,0,1, 0,0,6,5,7);
    step("wb_r9",        0,0,0,0,0,0,1,9,0, 0,0,6,5,7);
    // Reset while waiting; branch resolves right after
    step("add_r9b",      1,0,1,2,1,9,0,0,0, 0,0,6,5,7);
    step("bez_r9_st2",   1,1,9,0,0,0,0,0,1, 1,0,6,5,7);
    rst = 1'b1;
    step("rst_in_wait",  1,1,9,0,0,0,0,0,1, 1,0,6,5,8);
    rst = 1'b0;
    step("post_rst",     1,1,9,0,0,0,0,0,1, 0,1,0,0,0);
    step("idle4",        0,0,0,0,0,0,0,0,0, 0,0,1,1,0);
    // Saturation: small instance br_count pins at 15, taken_count still climbs
    for (int i = 0; i < 14; i++) begin
      step("sat_br",     1,2,0,0,0,0,0,0,0, 0,0,1+i,1,0);
    end
    step("sat_taken",    1,1,0,0,0,0,0,0,1, 0,1,15,1,0);
    step("idle5",        0,0,0,0,0,0,0,0,0, 0,0,16,2,0);
    step("add_r4",       1,0,1,2,1,4,0,0,0, 0,0,16,2,0);
    for (int j = 0; j < 17; j++) begin
      step("sat_stall",  1,1,4,0,0,0,0,0,0, 1,0,16,2,j);
    end
    step("drop_wb4",     0,0,0,0,0,0,1,4,0, 0,0,16,2,17);
    step("idle6",        0,0,0,0,0,0,0,0,0, 0,0,16,2,17);
    done = 1'b1;
  end

endmodule
